// File: rtl/traffic_phase_scheduler_if.sv
// Handshake bundle for traffic_phase_scheduler: timebase, requests, lamps and status.
// flash_req exists only when TRAFFIC_FLASH_EN is defined.
interface traffic_phase_scheduler_if;
  logic       tick;
  logic       ped_req;
  logic       side_sensor;
`ifdef TRAFFIC_FLASH_EN
  logic       flash_req;
`endif
  logic       MG, MY, MR;
  logic       SG, SY, SR;
  logic       pedLight;
  logic [2:0] phase;
  logic       ped_pending;
  logic       ped_ack;

  modport master (
`ifdef TRAFFIC_FLASH_EN
    output flash_req,
`endif
    output tick, ped_req, side_sensor,
    input  MG, MY, MR, SG, SY, SR, pedLight, phase, ped_pending, ped_ack
  );

  modport slave (
`ifdef TRAFFIC_FLASH_EN
    input  flash_req,
`endif
    input  tick, ped_req, side_sensor,
    output MG, MY, MR, SG, SY, SR, pedLight, phase, ped_pending, ped_ack
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Main/side intersection sequencer with demand-held main green and a pedestrian phase.
// Define TRAFFIC_FLASH_EN to add the flash_req input and the blinking FLASH state.
module traffic_phase_scheduler #(
  parameter int CNT_W        = 8,
  parameter int T_GREEN_MAIN = 8,
  parameter int T_YELLOW     = 3,
  parameter int T_ALLRED     = 2,
  parameter int T_GREEN_SIDE = 6,
  parameter int T_PED        = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  traffic_phase_scheduler_if.slave    bus
);

  localparam longint MAX_D = 64'd1 << CNT_W;

  if (T_GREEN_MAIN < 1 || T_GREEN_MAIN > MAX_D || T_YELLOW < 1 || T_YELLOW > MAX_D ||
      T_ALLRED < 1 || T_ALLRED > MAX_D || T_GREEN_SIDE < 1 || T_GREEN_SIDE > MAX_D ||
      T_PED < 1 || T_PED > MAX_D) begin : g_bad_duration
    $error("traffic_phase_scheduler: every duration must lie in 1..2**CNT_W");
  end

  // Expiry compares against duration-1 so a duration of 2**CNT_W still fits the timer.
  localparam logic [CNT_W-1:0] LIM_GM  = CNT_W'(T_GREEN_MAIN - 1);
  localparam logic [CNT_W-1:0] LIM_Y   = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LIM_AR  = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LIM_GS  = CNT_W'(T_GREEN_SIDE - 1);
  localparam logic [CNT_W-1:0] LIM_PED = CNT_W'(T_PED - 1);

  typedef enum logic [2:0] {
    GR  = 3'd0,
    YR  = 3'd1,
    RR1 = 3'd2,
    RG  = 3'd3,
    RY  = 3'd4,
    RR2 = 3'd5,
`ifdef TRAFFIC_FLASH_EN
    PED = 3'd6,
    FLASH = 3'd7
`else
    PED = 3'd6
`endif
  } state_t;

  // Lamp vector order: {MG, MY, MR, SG, SY, SR, pedLight}
  localparam logic [6:0] LAMPS_GR = 7'b1000010;

  function automatic logic [6:0] lamp_decode(input state_t s);
    case (s)
      GR:       lamp_decode = LAMPS_GR;
      YR:       lamp_decode = 7'b0100010;
      RR1, RR2: lamp_decode = 7'b0010010;
      RG:       lamp_decode = 7'b0011000;
      RY:       lamp_decode = 7'b0010100;
      PED:      lamp_decode = 7'b0010011;
      default:  lamp_decode = 7'b0000000;
    endcase
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt, lim;
  logic             expired;
  logic             sync1, sync2, sync3, ped_edge;
  logic             ped_pending, ped_pending_nxt;
  logic             side_demand, side_demand_nxt;
  logic             ped_ack, enter_ped, enter_rg;
  logic [6:0]       lamps, lamps_nxt;
`ifdef TRAFFIC_FLASH_EN
  logic             blink, blink_nxt;
`endif

  always_comb begin
    case (state)
      GR:       lim = LIM_GM;
      YR, RY:   lim = LIM_Y;
      RR1, RR2: lim = LIM_AR;
      RG:       lim = LIM_GS;
      PED:      lim = LIM_PED;
      default:  lim = '0;
    endcase
    // GR keeps counting to saturation, so >= keeps expiry true while main green is held.
    expired = bus.tick && (timer >= lim);

    state_nxt = state;
    case (state)
      GR:      if (expired && (side_demand || ped_pending)) state_nxt = YR;
      YR:      if (expired) state_nxt = RR1;
      RR1:     if (expired) state_nxt = side_demand ? RG : RR2;
      RG:      if (expired) state_nxt = RY;
      RY:      if (expired) state_nxt = RR2;
      RR2:     if (expired) state_nxt = ped_pending ? PED : GR;
      PED:     if (expired) state_nxt = GR;
      default: state_nxt = GR;
    endcase
`ifdef TRAFFIC_FLASH_EN
    if (bus.flash_req)
      state_nxt = FLASH;
    else if (state == FLASH)
      state_nxt = RR1;
`endif

    ped_edge        = sync2 & ~sync3;
    enter_ped       = (state_nxt == PED) && (state != PED);
    enter_rg        = (state_nxt == RG) && (state != RG);
    ped_pending_nxt = ped_edge | (ped_pending & ~enter_ped);
    side_demand_nxt = bus.side_sensor | (side_demand & ~enter_rg);

    if (state_nxt != state)
      timer_nxt = '0;
    else if (bus.tick && (timer != '1))
      timer_nxt = timer + 1'b1;
    else
      timer_nxt = timer;

    lamps_nxt = lamp_decode(state_nxt);
`ifdef TRAFFIC_FLASH_EN
    if ((state == FLASH) && (state_nxt == RR1))
      side_demand_nxt = 1'b0;
    if ((state_nxt == FLASH) && (state != FLASH))
      blink_nxt = 1'b0;
    else if ((state == FLASH) && bus.tick)
      blink_nxt = ~blink;
    else
      blink_nxt = blink;
    if (state_nxt == FLASH)
      lamps_nxt = {1'b0, blink_nxt, 3'b000, blink_nxt, 1'b0};
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= GR;
      timer       <= '0;
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sync3       <= 1'b0;
      ped_pending <= 1'b0;
      side_demand <= 1'b0;
      ped_ack     <= 1'b0;
      lamps       <= LAMPS_GR;
`ifdef TRAFFIC_FLASH_EN
      blink       <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      sync1       <= bus.ped_req;
      sync2       <= sync1;
      sync3       <= sync2;
      ped_pending <= ped_pending_nxt;
      side_demand <= side_demand_nxt;
      ped_ack     <= enter_ped;
      lamps       <= lamps_nxt;
`ifdef TRAFFIC_FLASH_EN
      blink       <= blink_nxt;
`endif
    end
  end

  assign {bus.MG, bus.MY, bus.MR, bus.SG, bus.SY, bus.SR, bus.pedLight} = lamps;
  assign bus.phase       = state;
  assign bus.ped_pending = ped_pending;
  assign bus.ped_ack     = ped_ack;

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Timed sequencer for a main/side street intersection with a pedestrian phase. It counts timebase ticks per phase and holds main-street green until there is demand. It latches pedestrian requests through a synchronizer and skips the side-green phase when no vehicle is waiting. Drives the lamp outputs directly and exports phase and status to the board-level test and debug logic.

Parameters:
CNT_W, 8, width of the phase timer in ticks
T_GREEN_MAIN, 8, minimum main green (GR) duration in ticks
T_YELLOW, 3, duration of YR and RY in ticks
T_ALLRED, 2, duration of RR1 and RR2 in ticks
T_GREEN_SIDE, 6, side green (RG) duration in ticks
T_PED, 5, pedestrian walk (PED) duration in ticks

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
tick  in  1  timebase enable pulse, one clk wide; timer advances only on tick
ped_req  in  1  asynchronous pedestrian button, level
side_sensor  in  1  side-street vehicle detect, synchronous level
MG, MY, MR  out  1 each  main street green/yellow/red
SG, SY, SR  out  1 each  side street green/yellow/red
pedLight  out  1  walk lamp
phase  out  3  current state encoding
ped_pending  out  1  latched pedestrian request
ped_ack  out  1  one-cycle pulse on entry to PED

Behaviour:
- State encodings: GR=0, YR=1, RR1=2, RG=3, RY=4, RR2=5, PED=6 (FLASH=7 only with option). Value 7 without the option returns to GR on the next clk.
- Reset asserted: state=GR, timer=0, ped_pending=0, side_demand=0, sync flops=0, ped_ack=0. Outputs: MG=1, SR=1, all other lamps 0, phase=0. Reset takes effect mid-phase with no completion of the current phase.
- Lamp outputs are a Moore decode of the state register:
  - GR: MG, SR
  - YR: MY, SR
  - RR1/RR2: MR, SR
  - RG: MR, SG
  - RY: MR, SY
  - PED: MR, SR, pedLight
- Timer: clears to 0 on the clk a state change takes effect. Otherwise it increments on tick and saturates at 2^CNT_W-1. A phase of duration D expires when tick=1 and timer==D-1. All durations must be >=1 and <=2^CNT_W; out-of-range values are illegal and flagged by an elaboration-time check.
- Transitions, evaluated at expiry:
  - GR: expired and (side_demand or ped_pending) -> YR. Otherwise hold GR, with the timer saturated and expiry remaining true.
  - YR -> RR1.
  - RR1 -> RG if side_demand, else -> RR2 (side phase skipped).
  - RG -> RY -> RR2.
  - RR2 -> PED if ped_pending, else -> GR.
  - PED -> GR.
- ped_req path: 2-flop synchronizer, then rising-edge detect.
  - A detected edge sets ped_pending.
  - Entry to PED clears ped_pending and pulses ped_ack.
  - If an edge is detected on the same clk as PED entry, set wins and ped_pending stays 1, serving the next cycle.
  - Requests during PED are held for the next cycle.
- side_demand: set by side_sensor=1 on any clk, cleared on entry to RG. If sensor=1 on the RG-entry clk, set wins.
- tick=0: the state machine holds and the timer holds; latches still update.

Optional Feature:
TRAFFIC_FLASH_EN
- With the macro: adds input port flash_req (1 bit, synchronous) and state FLASH=7.
  - flash_req=1 in any state moves to FLASH on the next clk, with priority over all other transitions.
  - In FLASH, a blink flop toggles on every tick. MY=blink, SR=blink, all other lamps 0. Blink clears on entry.
  - When flash_req drops, FLASH -> RR1, with side_demand forced to 0 on that transition, then the normal sequence continues.
  - ped_pending is preserved through FLASH.
- Without the macro: no port, no FLASH state, and encoding 7 is unreachable.

Test Plan:
- Reset release, tick=1 every clk, no demand -> GR held for 50 clks; MG=1, SR=1, phase=0 throughout.
- side_sensor=1 for 1 clk at clk 2 -> YR at clk 8 (3 clks), RR1 (2), RG (6), RY (3), RR2 (2), then GR at clk 24; side_demand=0 after RG entry.
- ped_req pulse (async, 3 clks wide) with no side demand -> ped_pending=1 within 3 clks. Sequence GR, YR, RR1, RR2, PED with RG skipped. ped_ack=1 for exactly 1 clk at PED entry, pedLight=1 for 5 clks, then GR.
- ped_req edge landing on the PED-entry clk -> ped_pending remains 1 after entry; a second PED follows in the next cycle.
- tick asserted every 4th clk -> each phase lasts 4x its duration in clks; no state change on non-tick clks.
- reset asserted during RG for 1 clk (asynchronous, mid-cycle) -> immediately MG=1, SR=1, SG=0, ped_pending=0. TRAFFIC_FLASH_EN build: flash_req=1 during RG -> FLASH next clk with MY/SR toggling each tick; on release, RR1 for 2 ticks, then RR2 and GR.
